// File: rtl/hack_boot_ctrl.sv
// ---------------------------------------------------------------------------
// hack_boot_ctrl
//
// Boot controller for a Hack-style CPU. It accepts an instruction image from
// a streaming loader, writes it word by word into the instruction ROM, holds
// the CPU in reset for a short settling period and then releases it.
//
// States: IDLE -> LOAD -> HOLD -> RUN, with ERR entered when the loader
// stalls for too long.
//
// Parameters
//   TIMEOUT      idle cycles allowed between accepted words while loading
//   MAX_WORDS    instruction ROM capacity in words (1..32768)
//   HOLD_CYCLES  cycles cpu_reset stays high after a load completes (>=1)
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        asynchronous active-low reset
//   load_start   one-cycle request to begin loading the ROM
//   run_req      one-cycle request to release the CPU with the current ROM
//   ld_valid     loader word valid
//   ld_data      loader instruction word
//   ld_last      marks ld_data as the final word of the image
//   ld_ready     controller accepts a word this cycle (state is LOAD)
//   rom_we       instruction-ROM write strobe
//   rom_addr     instruction-ROM write address
//   rom_wdata    instruction-ROM write data
//   cpu_reset    active-high reset to the CPU core, low only in RUN
//   busy         high in LOAD or HOLD
//   running      high in RUN
//   err          high in ERR
//   word_count   words accepted in the current or last load
// ---------------------------------------------------------------------------
module hack_boot_ctrl #(
  parameter int TIMEOUT     = 1024,
  parameter int MAX_WORDS   = 32768,
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        run_req,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        rom_we,
  output logic [14:0] rom_addr,
  output logic [15:0] rom_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        running,
  output logic        err,
  output logic [15:0] word_count
);

  // Counters only need to reach their terminal value minus one, because the
  // transition fires on the cycle that would otherwise hit the limit.
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t          state;
  logic [IW-1:0]   idle_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            accept;

  // The write pointer always equals the number of words accepted so far,
  // so word_count doubles as the ROM write pointer.
  assign accept = (state == LOAD) && ld_valid;

  // Status outputs are pure decodes of the state register.
  assign ld_ready  = (state == LOAD);
  assign busy      = (state == LOAD) || (state == HOLD);
  assign running   = (state == RUN);
  assign err       = (state == ERR);
  assign cpu_reset = (state != RUN);

  // Single state machine. The ROM write port is registered one cycle behind
  // acceptance, so a word accepted on the LOAD exit cycle still gets written
  // on the following cycle. Asserting reset drops the strobe immediately,
  // which cancels any write that was still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idle_cnt   <= '0;
      hold_cnt   <= '0;
      word_count <= '0;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_wdata  <= '0;
    end else begin
      rom_we <= 1'b0;
      if (accept) begin
        rom_we    <= 1'b1;
        rom_addr  <= word_count[14:0];
        rom_wdata <= ld_data;
      end

      case (state)
        IDLE: begin
          // A simultaneous load request takes priority over run.
          if (load_start) begin
            state      <= LOAD;
            word_count <= '0;
            idle_cnt   <= '0;
          end else if (run_req) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end

        LOAD: begin
          // Acceptance beats the timeout when both land on the same cycle.
          if (accept) begin
            word_count <= word_count + 16'd1;
            idle_cnt   <= '0;
            if (ld_last || (word_count == 16'(MAX_WORDS - 1))) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
            state    <= ERR;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            state <= RUN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        RUN, ERR: begin
          // word_count keeps the previous (possibly partial) count until a
          // new load begins.
          if (load_start) begin
            state      <= LOAD;
            word_count <= '0;
            idle_cnt   <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hack_boot_ctrl
//
// Drives two controller instances from the same stimulus: one with default
// parameters and a small one (TIMEOUT=8, MAX_WORDS=4, HOLD_CYCLES=2) so that
// timeout and capacity limits are reachable quickly. Expected outputs come
// from a reference model that tracks time stamps (when the hold ends, when
// the loader times out) rather than cycle counters.
// ---------------------------------------------------------------------------
module tb_hack_boot_ctrl;

  localparam int N = 2;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_HOLD = 2;
  localparam int S_RUN  = 3;
  localparam int S_ERR  = 4;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic        run_req;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;

  logic        rdy_o   [N];
  logic        we_o    [N];
  logic [14:0] addr_o  [N];
  logic [15:0] wdata_o [N];
  logic        cpur_o  [N];
  logic        busy_o  [N];
  logic        run_o   [N];
  logic        err_o   [N];
  logic [15:0] cnt_o   [N];

  int tests;
  int fails;
  int cyc;

  // Reference model state
  int m_mode   [N];
  int m_count  [N];
  int m_run_at [N];
  int m_err_at [N];
  int m_we     [N];
  int m_addr   [N];
  int m_data   [N];

  hack_boot_ctrl u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .run_req    (run_req),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (rdy_o[0]),
    .rom_we     (we_o[0]),
    .rom_addr   (addr_o[0]),
    .rom_wdata  (wdata_o[0]),
    .cpu_reset  (cpur_o[0]),
    .busy       (busy_o[0]),
    .running    (run_o[0]),
    .err        (err_o[0]),
    .word_count (cnt_o[0])
  );

  hack_boot_ctrl #(
    .TIMEOUT     (8),
    .MAX_WORDS   (4),
    .HOLD_CYCLES (2)
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .run_req    (run_req),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (rdy_o[1]),
    .rom_we     (we_o[1]),
    .rom_addr   (addr_o[1]),
    .rom_wdata  (wdata_o[1]),
    .cpu_reset  (cpur_o[1]),
    .busy       (busy_o[1]),
    .running    (run_o[1]),
    .err        (err_o[1]),
    .word_count (cnt_o[1])
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_of(input int i);
    return (i == 0) ? 1024 : 8;
  endfunction

  function automatic int mw_of(input int i);
    return (i == 0) ? 32768 : 4;
  endfunction

  function automatic int hc_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mode[i]   = S_IDLE;
      m_count[i]  = 0;
      m_run_at[i] = 0;
      m_err_at[i] = 0;
      m_we[i]     = 0;
      m_addr[i]   = 0;
      m_data[i]   = 0;
    end
  endtask

  task automatic model_begin_load(input int i);
    m_mode[i]   = S_LOAD;
    m_count[i]  = 0;
    m_err_at[i] = cyc + to_of(i);
  endtask

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      int acc;
      acc = ((m_mode[i] == S_LOAD) && ld_valid) ? 1 : 0;
      m_we[i] = acc;
      if (acc != 0) begin
        m_addr[i] = m_count[i];
        m_data[i] = int'(ld_data);
      end
      case (m_mode[i])
        S_IDLE: begin
          if (load_start) model_begin_load(i);
          else if (run_req) begin
            m_mode[i]   = S_HOLD;
            m_run_at[i] = cyc + hc_of(i);
          end
        end
        S_LOAD: begin
          if (acc != 0) begin
            m_count[i]  = m_count[i] + 1;
            m_err_at[i] = cyc + to_of(i);
            if (ld_last || (m_count[i] == mw_of(i))) begin
              m_mode[i]   = S_HOLD;
              m_run_at[i] = cyc + hc_of(i);
            end
          end else if (cyc == m_err_at[i]) begin
            m_mode[i] = S_ERR;
          end
        end
        S_HOLD: begin
          if (cyc == m_run_at[i]) m_mode[i] = S_RUN;
        end
        default: begin
          if (load_start) model_begin_load(i);
        end
      endcase
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("ld_ready[%0d]", i), 32'(rdy_o[i]), 32'(m_mode[i] == S_LOAD));
      checkOutput($sformatf("rom_we[%0d]", i), 32'(we_o[i]), 32'(m_we[i]));
      checkOutput($sformatf("rom_addr[%0d]", i), 32'(addr_o[i]), 32'(m_addr[i]));
      checkOutput($sformatf("rom_wdata[%0d]", i), 32'(wdata_o[i]), 32'(m_data[i]));
      checkOutput($sformatf("cpu_reset[%0d]", i), 32'(cpur_o[i]), 32'(m_mode[i] != S_RUN));
      checkOutput($sformatf("busy[%0d]", i), 32'(busy_o[i]),
                  32'((m_mode[i] == S_LOAD) || (m_mode[i] == S_HOLD)));
      checkOutput($sformatf("running[%0d]", i), 32'(run_o[i]), 32'(m_mode[i] == S_RUN));
      checkOutput($sformatf("err[%0d]", i), 32'(err_o[i]), 32'(m_mode[i] == S_ERR));
      checkOutput($sformatf("word_count[%0d]", i), 32'(cnt_o[i]), 32'(m_count[i]));
    end
  endtask

  // One clock cycle: model follows the edge, outputs sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (reset) model_edge();
    #1;
    check_all();
  endtask

  task automatic applyStimulus(input logic ls, input logic rr, input logic v,
                               input logic [15:0] d, input logic last);
    load_start = ls;
    run_req    = rr;
    ld_valid   = v;
    ld_data    = d;
    ld_last    = last;
    tick();
  endtask

  task automatic do_reset();
    load_start = 1'b0;
    run_req    = 1'b0;
    ld_valid   = 1'b0;
    ld_last    = 1'b0;
    reset      = 1'b0;
    model_reset();
    #1;
    check_all();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    cyc        = 0;
    reset      = 1'b0;
    load_start = 1'b0;
    run_req    = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = 16'h0000;
    ld_last    = 1'b0;
    model_reset();

    // Reset values before any clock edge
    #2;
    check_all();
    checkOutput("reset_cpu_reset", 32'(cpur_o[0]), 32'd1);
    checkOutput("reset_ld_ready", 32'(rdy_o[0]), 32'd0);
    tick();
    tick();
    reset = 1'b1;

    // Three-word image, back to back
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h3039, 1'b0);
    checkOutput("w0_we", 32'(we_o[0]), 32'd1);
    checkOutput("w0_addr", 32'(addr_o[0]), 32'd0);
    checkOutput("w0_data", 32'(wdata_o[0]), 32'h3039);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hEC10, 1'b0);
    checkOutput("w1_addr", 32'(addr_o[0]), 32'd1);
    checkOutput("w1_data", 32'(wdata_o[0]), 32'hEC10);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h5BA0, 1'b1);
    checkOutput("w2_we", 32'(we_o[0]), 32'd1);
    checkOutput("w2_addr", 32'(addr_o[0]), 32'd2);
    checkOutput("w2_data", 32'(wdata_o[0]), 32'h5BA0);
    checkOutput("w2_count", 32'(cnt_o[0]), 32'd3);
    checkOutput("w2_ready", 32'(rdy_o[0]), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("hold1_we", 32'(we_o[0]), 32'd0);
    checkOutput("hold1_cpu_reset", 32'(cpur_o[0]), 32'd1);
    tick();
    tick();
    checkOutput("hold3_cpu_reset", 32'(cpur_o[0]), 32'd1);
    tick();
    checkOutput("run_cpu_reset", 32'(cpur_o[0]), 32'd0);
    checkOutput("run_running", 32'(run_o[0]), 32'd1);

    // Loader stall of TIMEOUT cycles from RUN -> LOAD -> ERR
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("reload_cpu_reset", 32'(cpur_o[0]), 32'd1);
    for (int k = 0; k < 1023; k++) tick();
    checkOutput("pre_timeout_err", 32'(err_o[0]), 32'd0);
    tick();
    checkOutput("timeout_err", 32'(err_o[0]), 32'd1);
    checkOutput("timeout_cpu_reset", 32'(cpur_o[0]), 32'd1);
    checkOutput("timeout_count", 32'(cnt_o[0]), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("err_reload_err", 32'(err_o[0]), 32'd0);
    checkOutput("err_reload_busy", 32'(busy_o[0]), 32'd1);

    // Small instance: word arrives on the 8th idle cycle, then a real timeout
    for (int k = 0; k < 7; k++) tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
    checkOutput("edge_accept_err", 32'(err_o[1]), 32'd0);
    checkOutput("edge_accept_we", 32'(we_o[1]), 32'd1);
    checkOutput("edge_accept_count", 32'(cnt_o[1]), 32'd1);
    ld_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    checkOutput("idle7_busy", 32'(busy_o[1]), 32'd1);
    tick();
    checkOutput("idle8_err", 32'(err_o[1]), 32'd1);

    // Small instance capacity: 6 words offered, 4 taken
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b0);
      if (k == 4) begin
        checkOutput("full_ready", 32'(rdy_o[1]), 32'd0);
        checkOutput("full_count", 32'(cnt_o[1]), 32'd4);
        checkOutput("full_addr", 32'(addr_o[1]), 32'd3);
      end
      if (k == 5) checkOutput("full_no_we", 32'(we_o[1]), 32'd0);
    end
    checkOutput("big_count", 32'(cnt_o[0]), 32'd7);
    ld_valid = 1'b0;

    // load_start and run_req together in IDLE: load wins
    do_reset();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    checkOutput("both_ready", 32'(rdy_o[0]), 32'd1);

    // run_req alone from IDLE: RUN after HOLD_CYCLES
    do_reset();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    run_req = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("runreq_hold_running", 32'(run_o[0]), 32'd0);
    tick();
    checkOutput("runreq_running", 32'(run_o[0]), 32'd1);

    // Reset mid-LOAD with a write in flight
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
    checkOutput("inflight_we", 32'(we_o[0]), 32'd1);
    reset = 1'b0;
    model_reset();
    #1;
    checkOutput("abort_we", 32'(we_o[0]), 32'd0);
    checkOutput("abort_count", 32'(cnt_o[0]), 32'd0);
    checkOutput("abort_busy", 32'(busy_o[0]), 32'd0);
    checkOutput("abort_cpu_reset", 32'(cpur_o[0]), 32'd1);
    check_all();
    tick();
    reset = 1'b1;
    ld_valid = 1'b0;
    tick();
    checkOutput("post_abort_ready", 32'(rdy_o[0]), 32'd0);
    checkOutput("post_abort_busy", 32'(busy_o[0]), 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if (($urandom % 700) == 0) begin
        do_reset();
      end else begin
        applyStimulus(($urandom % 40) == 0, ($urandom % 30) == 0,
                      ($urandom % 3) != 0, 16'($urandom), ($urandom % 12) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hack_boot_ctrl.md
HACK_BOOT_CTRL -- requirements
Module: hack_boot_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1024: idle cycles allowed between accepted words in LOAD before error.
REQ-002 Parameter MAX_WORDS, default 32768: instruction ROM capacity in words (1..32768).
REQ-003 Parameter HOLD_CYCLES, default 4: cycles cpu_reset stays high after load completes (>=1).
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, asynchronous assert, active-low; de-assertion synchronous to clk.
REQ-006 load_start  input  1  one-cycle request to begin loading the ROM.
REQ-007 run_req  input  1  one-cycle request to release the CPU with the current ROM contents.
REQ-008 ld_valid  input  1  loader word valid.
REQ-009 ld_data  input  16  loader instruction word.
REQ-010 ld_last  input  1  qualifies ld_data as the final word of the image.
REQ-011 ld_ready  output  1  controller accepts a word this cycle.
REQ-012 rom_we  output  1  instruction-ROM write strobe.
REQ-013 rom_addr  output  15  instruction-ROM write address.
REQ-014 rom_wdata  output  16  instruction-ROM write data.
REQ-015 cpu_reset  output  1  active-high reset to the CPU core.
REQ-016 busy  output  1  high in LOAD or HOLD.
REQ-017 running  output  1  high in RUN.
REQ-018 err  output  1  high in ERR.
REQ-019 word_count  output  16  words accepted in the current or last load.

Function
REQ-020 Five states SHALL exist: IDLE, LOAD, HOLD, RUN, ERR; busy/running/err SHALL be decoded from registered state only.
REQ-021 cpu_reset SHALL be 1 in IDLE, LOAD, HOLD, ERR and 0 only in RUN.
REQ-022 IDLE: load_start -> LOAD; else run_req -> HOLD; both in one cycle -> LOAD (load wins).
REQ-023 Entry to LOAD SHALL clear word_count, write pointer and idle counter to 0.
REQ-024 ld_ready SHALL be 1 exactly when state is LOAD; a word is accepted on a cycle with ld_valid & ld_ready.
REQ-025 An accepted word SHALL produce rom_we=1, rom_addr=pointer, rom_wdata=ld_data on the following cycle (1-cycle registered latency); rom_we otherwise 0.
REQ-026 Each accepted word SHALL increment pointer and word_count by 1.
REQ-027 LOAD exit to HOLD SHALL occur after acceptance of a word with ld_last=1, or of the word at pointer MAX_WORDS-1 (capacity full), whichever first; no further words accepted.
REQ-028 In LOAD the idle counter SHALL increment each cycle without acceptance and clear on acceptance; on reaching TIMEOUT, state -> ERR.
REQ-029 Acceptance in the same cycle the idle counter reaches TIMEOUT SHALL win (word written, no ERR).
REQ-030 load_start while in LOAD or HOLD SHALL be ignored.
REQ-031 HOLD SHALL last exactly HOLD_CYCLES cycles, then -> RUN; cpu_reset falls on the RUN entry edge.
REQ-032 RUN: load_start -> LOAD (cpu_reset rises next cycle); run_req ignored.
REQ-033 ERR: load_start -> LOAD; run_req ignored; word_count holds the partial count.
REQ-034 A pending rom_we from the last accepted word SHALL still issue in the cycle after LOAD exit.

Reset
REQ-035 While reset=0: state IDLE, cpu_reset=1, ld_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, busy=0, running=0, err=0, word_count=0, all counters 0.
REQ-036 Reset asserted mid-LOAD or mid-RUN SHALL abort immediately, with no further rom_we and no ROM write from an in-flight accepted word.

Verification
REQ-037 load_start, then words 0x3039, 0xEC10, 0x5BA0 (last) back-to-back -> rom_we at addr 0,1,2 with those data, word_count=3, HOLD 4 cycles, cpu_reset=0 on 5th cycle after last accept.
REQ-038 load_start, ld_valid=0 for 1024 cycles -> err=1, cpu_reset=1, word_count=0; then load_start -> LOAD, err=0.
REQ-039 TIMEOUT=8, word accepted exactly on the 8th idle cycle -> no ERR, write occurs, counter cleared.
REQ-040 MAX_WORDS=4, stream 6 words, none last -> writes at addr 0..3 only, ld_ready=0 after 4th, word_count=4, -> HOLD.
REQ-041 load_start and run_req in the same IDLE cycle -> LOAD, not HOLD; run_req alone from IDLE -> RUN after 4 cycles, no rom_we.
REQ-042 reset=0 pulse during LOAD after 2 accepted words -> all outputs at reset values in the same cycle, no rom_we for an in-flight word, IDLE after release.
